// File: rtl/store_buffer.sv
// In-order store buffer between execute and the data-memory write port.
// Stores drain head-first; loads can forward from the youngest matching store.
module store_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_ready,
    input  logic                       drain_hold,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       wr_enable,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_hit,
    output logic [DATA_W-1:0]          ld_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              push;
    logic              pop;

    assign empty     = (count == '0);
    assign st_ready  = (count < CNT_W'(DEPTH));
    assign wr_enable = !empty && !drain_hold;
    assign push      = st_valid && st_ready;
    assign pop       = wr_enable;
    assign wr_addr   = empty ? '0 : addr_mem[head];
    assign wr_data   = empty ? '0 : data_mem[head];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry storage is deliberately not reset; head/tail/count decide which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_mem[tail] <= st_addr;
            data_mem[tail] <= st_data;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        logic [PTR_W-1:0] idx;
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (addr_mem[idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_mem[idx];
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// all compared against a queue-based model of the buffer contents.
module tb_store_buffer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              drain_hold;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_enable;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic [CNT_W-1:0]  count;
    logic              empty;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t model_q[$];
    int     vectors     = 0;
    int     miscompares = 0;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .drain_hold(drain_hold),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .count(count), .empty(empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected outputs come straight from the queue: head is q[0], youngest is q[$].
    task automatic compare_outputs();
        logic              exp_hit;
        logic [DATA_W-1:0] exp_ld;
        entry_t            head_e;
        int                n;
        n       = model_q.size();
        exp_hit = 1'b0;
        exp_ld  = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!exp_hit && model_q[i].addr == ld_addr) begin
                exp_hit = 1'b1;
                exp_ld  = model_q[i].data;
            end
        end
        head_e = (n != 0) ? model_q[0] : '0;
        check("count",     count,     n);
        check("empty",     empty,     n == 0);
        check("st_ready",  st_ready,  n < DEPTH);
        check("wr_enable", wr_enable, (n != 0) && !drain_hold);
        check("wr_addr",   wr_addr,   head_e.addr);
        check("wr_data",   wr_data,   head_e.data);
        check("ld_hit",    ld_hit,    exp_hit);
        check("ld_data",   ld_data,   exp_ld);
    endtask

    // Inputs are already driven; compare, then advance model and DUT by one edge.
    task automatic cycle();
        logic do_push;
        logic do_pop;
        entry_t e;
        #1;
        compare_outputs();
        do_push = st_valid && (model_q.size() < DEPTH);
        do_pop  = (model_q.size() != 0) && !drain_hold;
        e.addr  = st_addr;
        e.data  = st_data;
        @(posedge clock);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(e);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic hold, input logic [ADDR_W-1:0] la);
        st_valid   = v;
        st_addr    = a;
        st_data    = d;
        drain_hold = hold;
        ld_addr    = la;
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        st_valid = 1'b0; st_addr = '0; st_data = '0; drain_hold = 1'b0; ld_addr = '0;
        #1;
        compare_outputs();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single store, then observe the write and the return to empty.
        drive(1'b1, 20'h00010, 16'hBEEF, 1'b0, 20'h00010);
        drive(1'b0, 20'h0, 16'h0, 1'b0, 20'h00010);
        check("single_wr_addr_seen", model_q.size(), 0);
        drive(1'b0, 20'h0, 16'h0, 1'b0, 20'h0);

        // Fill with hold, a 9th store is refused, then drain in order.
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, ADDR_W'(i), DATA_W'($urandom), 1'b1, ADDR_W'(i));
        drive(1'b1, 20'h00008, 16'hDEAD, 1'b1, 20'h00008);
        for (int i = 0; i < DEPTH + 1; i++)
            drive(1'b0, 20'h0, 16'h0, 1'b0, ADDR_W'(i));

        // Forwarding picks the youngest match.
        drive(1'b1, 20'h00005, 16'h1111, 1'b1, 20'h00005);
        drive(1'b1, 20'h00005, 16'h2222, 1'b1, 20'h00005);
        drive(1'b0, 20'h0, 16'h0, 1'b1, 20'h00005);
        drive(1'b0, 20'h0, 16'h0, 1'b1, 20'h00006);
        for (int i = 0; i < 3; i++) drive(1'b0, 20'h0, 16'h0, 1'b0, 20'h00005);

        // Streaming one store per cycle, pointers wrap several times.
        for (int i = 0; i < 20; i++)
            drive(1'b1, ADDR_W'(20'h100 + i), DATA_W'($urandom), 1'b0, ADDR_W'(20'h100 + i - 1));
        for (int i = 0; i < 2; i++) drive(1'b0, 20'h0, 16'h0, 1'b0, 20'h0);

        // Full with drain: pop only, then st_ready returns.
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, ADDR_W'(20'h200 + i), DATA_W'($urandom), 1'b1, 20'h0);
        drive(1'b1, 20'h00300, 16'h3333, 1'b0, 20'h00300);
        drive(1'b0, 20'h0, 16'h0, 1'b1, 20'h00300);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 20'h0, 16'h0, 1'b0, 20'h0);

        // Asynchronous reset between edges with 5 entries buffered.
        for (int i = 0; i < 5; i++)
            drive(1'b1, ADDR_W'(20'h400 + i), DATA_W'($urandom), 1'b1, 20'h00402);
        st_valid = 1'b0; drain_hold = 1'b0; ld_addr = 20'h00402;
        #1;
        reset = 1'b1;
        #1;
        model_q.delete();
        compare_outputs();
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) drive(1'b0, 20'h0, 16'h0, 1'b0, 20'h00402);

        // Random traffic over a small address range so forwarding hits often.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
                  1'($urandom_range(0, 9) < 3), ADDR_W'($urandom_range(0, 7)));
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 20'h0, 16'h0, 1'b0, 20'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of buffered store entries, power of two, at least 2.
REQ-002 Parameter ADDR_W, default 20: data-memory word address width.
REQ-003 Parameter DATA_W, default 16: data-memory word width.
REQ-004 Port clock  in  1: rising-edge clock shared with the data memory.
REQ-005 Port reset  in  1: reset, asynchronous, active-high.
REQ-006 Port st_valid  in  1: execute stage presents a store this cycle.
REQ-007 Port st_addr  in  ADDR_W: store word address.
REQ-008 Port st_data  in  DATA_W: store data.
REQ-009 Port st_ready  out  1: buffer can accept a store this cycle.
REQ-010 Port drain_hold  in  1: when high, no entry is drained this cycle.
REQ-011 Port wr_addr  out  ADDR_W: data-memory write-port address.
REQ-012 Port wr_data  out  DATA_W: data-memory write-port data.
REQ-013 Port wr_enable  out  1: data-memory write-port enable.
REQ-014 Port ld_addr  in  ADDR_W: load address from execute, used for forwarding lookup.
REQ-015 Port ld_hit  out  1: a buffered store matches ld_addr.
REQ-016 Port ld_data  out  DATA_W: data of the youngest matching buffered store, 0 when ld_hit is low.
REQ-017 Port count  out  log2(DEPTH)+1: number of valid entries.
REQ-018 Port empty  out  1: count equals 0.

Function
REQ-019 The buffer SHALL be an in-order FIFO of {addr, data} entries with head/tail pointers that wrap modulo DEPTH and a separate occupancy counter.
REQ-020 st_ready SHALL be high exactly when count < DEPTH, independent of same-cycle drain; when full, st_ready stays low even while an entry drains.
REQ-021 A store SHALL be enqueued at the tail on a rising edge where st_valid and st_ready are both high; st_valid with st_ready low is ignored and the producer holds.
REQ-022 wr_enable SHALL be combinational: high when count != 0 and drain_hold is low; wr_addr and wr_data SHALL always show the head entry, and show 0 when empty.
REQ-023 The head entry SHALL be popped on every rising edge where wr_enable is high; the data memory writes it on that same edge.
REQ-024 Latency: a store accepted into an empty buffer on edge N SHALL drive wr_enable during cycle N+1 and be written on edge N+1.
REQ-025 Simultaneous enqueue and pop SHALL leave count unchanged, and both pointers SHALL advance.
REQ-026 ld_hit SHALL be combinational and high if any valid entry, including the head being drained this cycle, has addr equal to ld_addr.
REQ-027 When several entries match, ld_data SHALL return the youngest, meaning the one closest to the tail in program order.
REQ-028 A store being enqueued on the current edge SHALL NOT be visible to forwarding until the following cycle.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL NOT change ordering or forwarding results.
REQ-030 Pop SHALL NOT occur when empty and enqueue SHALL NOT occur when full; no state changes in either case.

Reset
REQ-031 While reset is high, head, tail and count SHALL be 0, giving empty=1, st_ready=1, wr_enable=0, ld_hit=0, wr_addr=0, wr_data=0 and ld_data=0.
REQ-032 Entry storage SHALL NOT be cleared; valid-entry tracking alone governs all outputs.
REQ-033 A reset asserted mid-operation SHALL discard all buffered stores, and none SHALL reach wr_enable after reset deasserts.

Verification
REQ-034 Single store: enqueue addr 0x00010 data 0xBEEF into an empty buffer, drain_hold=0 -> next cycle wr_enable=1, wr_addr=0x00010, wr_data=0xBEEF, and the cycle after that empty=1.
REQ-035 Fill: drain_hold=1, push 8 stores with addresses 0..7 -> count=8, st_ready=0, and a 9th st_valid is ignored; release hold -> addresses 0..7 are written in order over 8 consecutive cycles.
REQ-036 Forwarding: drain_hold=1, push (0x00005, 0x1111) then (0x00005, 0x2222), set ld_addr=0x00005 -> ld_hit=1, ld_data=0x2222; set ld_addr=0x00006 -> ld_hit=0, ld_data=0.
REQ-037 Streaming: push one store per cycle for 20 cycles with hold low -> count stays at 1 in steady state, pointers wrap, and all 20 writes appear in order.
REQ-038 Reset mid-operation: with 5 entries buffered, pulse reset asynchronously between edges -> outputs immediately take reset values, and no write occurs afterwards.
REQ-039 Full with drain: at count=8 with hold low and st_valid=1 -> one pop and no enqueue, count=7, then st_ready=1.
